// File: rtl/control_pkg.sv
// Shared control-bundle layout, forwarding encodings and the bubble constant
// used by the decoder and the pipeline control registers.
package control_pkg;

    localparam int unsigned WB_WIDTH   = 2;
    localparam int unsigned MEM_WIDTH  = 2;
    localparam int unsigned CALC_WIDTH = 4;

    localparam int unsigned REG_WRITE  = 1;
    localparam int unsigned MEM_TO_REG = 0;
    localparam int unsigned MEM_READ   = 1;
    localparam int unsigned MEM_WRITE  = 0;
    localparam int unsigned REG_DST    = 3;
    localparam int unsigned ALU_OP_MSB = 2;
    localparam int unsigned ALU_OP_LSB = 1;
    localparam int unsigned ALU_SRC    = 0;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b01;

    typedef struct packed {
        logic [CALC_WIDTH-1:0] calc;
        logic [MEM_WIDTH-1:0]  mem;
        logic [WB_WIDTH-1:0]   wb;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select for one source register.
// MEM wins over WB because it holds the newer result.
module forward_unit
    import control_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG       = 0
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_i,
    input  logic                      mem_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_dest_i,
    input  logic                      wb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_dest_i,
    output fwd_sel_t                  sel_o
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg = REG_ADDR_WIDTH'(ZERO_REG);

    always_comb begin
        sel_o = FWD_REG;
        if (mem_reg_write_i && (mem_dest_i != ZeroReg) && (mem_dest_i == src_i)) begin
            sel_o = FWD_MEM;
        end else if (wb_reg_write_i && (wb_dest_i != ZeroReg) && (wb_dest_i == src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// Carries decoded control bundles through ID/EX, EX/MEM and MEM/WB, inserting
// bubbles on load-use, flush and invalid issue, and drives EX forwarding selects.
module control_pipeline
    import control_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      idValid,
    input  logic [WB_WIDTH-1:0]       idWriteBackControl,
    input  logic [MEM_WIDTH-1:0]      idMemAccessControl,
    input  logic [CALC_WIDTH-1:0]     idCalculationControl,
    input  logic [REG_ADDR_WIDTH-1:0] idRs,
    input  logic [REG_ADDR_WIDTH-1:0] idRt,
    input  logic [REG_ADDR_WIDTH-1:0] idRd,
    input  logic                      extStall,
    input  logic                      flush,
    output logic                      hazardStall,
    output logic [CALC_WIDTH-1:0]     exCalculationControl,
    output logic [MEM_WIDTH-1:0]      exMemAccessControl,
    output logic [WB_WIDTH-1:0]       exWriteBackControl,
    output logic [REG_ADDR_WIDTH-1:0] exRs,
    output logic [REG_ADDR_WIDTH-1:0] exRt,
    output logic [MEM_WIDTH-1:0]      memMemAccessControl,
    output logic [WB_WIDTH-1:0]       memWriteBackControl,
    output logic [REG_ADDR_WIDTH-1:0] memDest,
    output logic [WB_WIDTH-1:0]       wbWriteBackControl,
    output logic [REG_ADDR_WIDTH-1:0] wbDest,
    output logic [1:0]                forwardA,
    output logic [1:0]                forwardB
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg = REG_ADDR_WIDTH'(ZERO_REG);

    ctrl_t                     ex_ctrl_q, ex_ctrl_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
    logic [MEM_WIDTH-1:0]      mem_mem_q, mem_mem_d;
    logic [WB_WIDTH-1:0]       mem_wb_q, mem_wb_d;
    logic [REG_ADDR_WIDTH-1:0] mem_dest_q, mem_dest_d;
    logic [WB_WIDTH-1:0]       wb_wb_q, wb_wb_d;
    logic [REG_ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
    logic                      load_use;

    assign load_use = ex_ctrl_q.mem[MEM_READ] && (ex_rt_q != ZeroReg) && idValid &&
                      ((ex_rt_q == idRs) || (ex_rt_q == idRt));
    assign hazardStall = load_use && !extStall;

    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rd_d    = ex_rd_q;
        mem_mem_d  = mem_mem_q;
        mem_wb_d   = mem_wb_q;
        mem_dest_d = mem_dest_q;
        wb_wb_d    = wb_wb_q;
        wb_dest_d  = wb_dest_q;
        // extStall freezes everything, which also defers any pending flush.
        if (!extStall) begin
            wb_wb_d    = mem_wb_q;
            wb_dest_d  = mem_dest_q;
            mem_mem_d  = ex_ctrl_q.mem;
            mem_wb_d   = ex_ctrl_q.wb;
            mem_dest_d = ex_ctrl_q.calc[REG_DST] ? ex_rd_q : ex_rt_q;
            if (flush || load_use || !idValid) begin
                ex_ctrl_d = BUBBLE;
                ex_rs_d   = '0;
                ex_rt_d   = '0;
                ex_rd_d   = '0;
            end else begin
                ex_ctrl_d = '{calc: idCalculationControl, mem: idMemAccessControl,
                              wb: idWriteBackControl};
                ex_rs_d   = idRs;
                ex_rt_d   = idRt;
                ex_rd_d   = idRd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl_q  <= BUBBLE;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            mem_mem_q  <= '0;
            mem_wb_q   <= '0;
            mem_dest_q <= '0;
            wb_wb_q    <= '0;
            wb_dest_q  <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            mem_mem_q  <= mem_mem_d;
            mem_wb_q   <= mem_wb_d;
            mem_dest_q <= mem_dest_d;
            wb_wb_q    <= wb_wb_d;
            wb_dest_q  <= wb_dest_d;
        end
    end

    assign exCalculationControl = ex_ctrl_q.calc;
    assign exMemAccessControl   = ex_ctrl_q.mem;
    assign exWriteBackControl   = ex_ctrl_q.wb;
    assign exRs                 = ex_rs_q;
    assign exRt                 = ex_rt_q;
    assign memMemAccessControl  = mem_mem_q;
    assign memWriteBackControl  = mem_wb_q;
    assign memDest              = mem_dest_q;
    assign wbWriteBackControl   = wb_wb_q;
    assign wbDest               = wb_dest_q;

    forward_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .ZERO_REG      (ZERO_REG)
    ) u_forward_a (
        .src_i          (ex_rs_q),
        .mem_reg_write_i(mem_wb_q[REG_WRITE]),
        .mem_dest_i     (mem_dest_q),
        .wb_reg_write_i (wb_wb_q[REG_WRITE]),
        .wb_dest_i      (wb_dest_q),
        .sel_o          (forwardA)
    );

    forward_unit #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .ZERO_REG      (ZERO_REG)
    ) u_forward_b (
        .src_i          (ex_rt_q),
        .mem_reg_write_i(mem_wb_q[REG_WRITE]),
        .mem_dest_i     (mem_dest_q),
        .wb_reg_write_i (wb_wb_q[REG_WRITE]),
        .wb_dest_i      (wb_dest_q),
        .sel_o          (forwardB)
    );

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: directed stimulus pushes expected
// output values tagged with the cycle they are due; a monitor checks them.
module tb_control_pipeline;

    localparam int HAZ = 0, EXC = 1, EXM = 2, EXW = 3, EXRS = 4, EXRT = 5, MEMM = 6;
    localparam int MEMW = 7, MEMD = 8, WBW = 9, WBD = 10, FWA = 11, FWB = 12, NSEL = 13;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
        int         tid;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       idValid;
    logic [1:0] idWriteBackControl;
    logic [1:0] idMemAccessControl;
    logic [3:0] idCalculationControl;
    logic [4:0] idRs, idRt, idRd;
    logic       extStall, flush;
    logic       hazardStall;
    logic [3:0] exCalculationControl;
    logic [1:0] exMemAccessControl, exWriteBackControl;
    logic [4:0] exRs, exRt;
    logic [1:0] memMemAccessControl, memWriteBackControl;
    logic [4:0] memDest;
    logic [1:0] wbWriteBackControl;
    logic [4:0] wbDest;
    logic [1:0] forwardA, forwardB;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tid = 0;
    exp_t sb[$];
    string names[NSEL] = '{"hazardStall", "exCalc", "exMem", "exWb", "exRs", "exRt",
                           "memMem", "memWb", "memDest", "wbWb", "wbDest", "forwardA",
                           "forwardB"};

    control_pipeline #(
        .REG_ADDR_WIDTH(5),
        .ZERO_REG      (0)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .idValid             (idValid),
        .idWriteBackControl  (idWriteBackControl),
        .idMemAccessControl  (idMemAccessControl),
        .idCalculationControl(idCalculationControl),
        .idRs                (idRs),
        .idRt                (idRt),
        .idRd                (idRd),
        .extStall            (extStall),
        .flush               (flush),
        .hazardStall         (hazardStall),
        .exCalculationControl(exCalculationControl),
        .exMemAccessControl  (exMemAccessControl),
        .exWriteBackControl  (exWriteBackControl),
        .exRs                (exRs),
        .exRt                (exRt),
        .memMemAccessControl (memMemAccessControl),
        .memWriteBackControl (memWriteBackControl),
        .memDest             (memDest),
        .wbWriteBackControl  (wbWriteBackControl),
        .wbDest              (wbDest),
        .forwardA            (forwardA),
        .forwardB            (forwardB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] get_out(input int s);
        case (s)
            HAZ:     return {7'b0, hazardStall};
            EXC:     return {4'b0, exCalculationControl};
            EXM:     return {6'b0, exMemAccessControl};
            EXW:     return {6'b0, exWriteBackControl};
            EXRS:    return {3'b0, exRs};
            EXRT:    return {3'b0, exRt};
            MEMM:    return {6'b0, memMemAccessControl};
            MEMW:    return {6'b0, memWriteBackControl};
            MEMD:    return {3'b0, memDest};
            WBW:     return {6'b0, wbWriteBackControl};
            WBD:     return {3'b0, wbDest};
            FWA:     return {6'b0, forwardA};
            FWB:     return {6'b0, forwardB};
            default: return 8'hff;
        endcase
    endfunction

    // Monitor: compare every scoreboard entry due in the current cycle.
    always @(negedge clk) begin
        exp_t keep[$];
        logic [7:0] got;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                got = get_out(sb[i].sel);
                checks++;
                if (got !== sb[i].val) begin
                    errors++;
                    $display("FAIL test%0d %s cycle %0d: got %0h expected %0h", sb[i].tid,
                             names[sb[i].sel], cyc, got, sb[i].val);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic push_exp(input int dc, input int s, input logic [7:0] v);
        exp_t e;
        e.cyc = cyc + dc;
        e.sel = s;
        e.val = v;
        e.tid = tid;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] mem,
                         input logic [3:0] calc, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        idValid              = v;
        idWriteBackControl   = wb;
        idMemAccessControl   = mem;
        idCalculationControl = calc;
        idRs                 = rs;
        idRt                 = rt;
        idRd                 = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 2'b00, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset    = 1'b1;
        extStall = 1'b0;
        flush    = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0);
        tick();

        // Reset holds everything at bubble even with a full bundle offered.
        tid = 0;
        drive(1'b1, 2'b11, 2'b10, 4'b1011, 5'd1, 5'd2, 5'd3);
        for (int s = 0; s < NSEL; s++) push_exp(0, s, 8'h00);
        tick();
        reset = 1'b0;
        idle(1);

        // Straight flow, 1/2/3 cycle latency, regDst selects rd.
        tid = 1;
        drive(1'b1, 2'b10, 2'b00, 4'b1100, 5'd1, 5'd2, 5'd3);
        push_exp(1, EXC, 8'h0c);
        push_exp(1, EXM, 8'h00);
        push_exp(1, EXW, 8'h02);
        push_exp(1, EXRS, 8'd1);
        push_exp(1, EXRT, 8'd2);
        push_exp(1, FWA, 8'h00);
        push_exp(2, MEMW, 8'h02);
        push_exp(2, MEMD, 8'd3);
        push_exp(3, WBW, 8'h02);
        push_exp(3, WBD, 8'd3);
        tick();
        drive(1'b0, 2'b00, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd0);
        push_exp(1, EXC, 8'h00);
        push_exp(1, EXW, 8'h00);
        idle(4);

        // Load-use: one stall cycle, one bubble, then WB forwarding.
        tid = 2;
        drive(1'b1, 2'b11, 2'b10, 4'b0011, 5'd5, 5'd4, 5'd9);
        push_exp(1, EXM, 8'h02);
        push_exp(1, EXRT, 8'd4);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b1100, 5'd4, 5'd6, 5'd8);
        push_exp(0, HAZ, 8'h01);
        push_exp(1, EXC, 8'h00);
        push_exp(1, EXM, 8'h00);
        push_exp(1, MEMW, 8'h03);
        push_exp(1, MEMD, 8'd4);
        tick();
        push_exp(0, HAZ, 8'h00);
        push_exp(1, EXC, 8'h0c);
        push_exp(1, EXRS, 8'd4);
        push_exp(1, WBW, 8'h03);
        push_exp(1, WBD, 8'd4);
        push_exp(1, FWA, 8'h01);
        push_exp(1, FWB, 8'h00);
        tick();
        idle(4);

        // Forward priority: MEM beats WB; register zero never forwards.
        tid = 3;
        drive(1'b1, 2'b10, 2'b00, 4'b1000, 5'd1, 5'd2, 5'd7);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b1000, 5'd3, 5'd4, 5'd7);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b0000, 5'd7, 5'd7, 5'd1);
        push_exp(1, FWA, 8'h02);
        push_exp(1, FWB, 8'h02);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b1000, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b1000, 5'd3, 5'd4, 5'd0);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b0000, 5'd0, 5'd0, 5'd5);
        push_exp(1, FWA, 8'h00);
        push_exp(1, FWB, 8'h00);
        tick();
        idle(4);

        // extStall: three in flight held three cycles, loadUse masked, flush ignored.
        tid = 4;
        drive(1'b1, 2'b10, 2'b00, 4'b1000, 5'd1, 5'd2, 5'd10);
        tick();
        drive(1'b1, 2'b00, 2'b01, 4'b0001, 5'd20, 5'd21, 5'd22);
        tick();
        drive(1'b1, 2'b11, 2'b10, 4'b0011, 5'd5, 5'd11, 5'd12);
        tick();
        extStall = 1'b1;
        drive(1'b1, 2'b10, 2'b00, 4'b0000, 5'd11, 5'd3, 5'd4);
        for (int k = 0; k < 4; k++) begin
            push_exp(k, EXC, 8'h03);
            push_exp(k, EXRT, 8'd11);
            push_exp(k, MEMM, 8'h01);
            push_exp(k, MEMD, 8'd21);
            push_exp(k, WBW, 8'h02);
            push_exp(k, WBD, 8'd10);
        end
        push_exp(0, HAZ, 8'h00);
        tick();
        flush = 1'b1;
        push_exp(0, HAZ, 8'h00);
        tick();
        flush = 1'b0;
        push_exp(0, HAZ, 8'h00);
        tick();
        extStall = 1'b0;
        push_exp(0, HAZ, 8'h01);
        push_exp(1, EXC, 8'h00);
        push_exp(1, MEMM, 8'h02);
        push_exp(1, MEMD, 8'd11);
        push_exp(1, WBW, 8'h00);
        push_exp(1, WBD, 8'd21);
        tick();
        idle(4);

        // Flush squashes the entering instruction; older stages still advance.
        tid = 5;
        drive(1'b1, 2'b10, 2'b00, 4'b1000, 5'd1, 5'd2, 5'd16);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'b10, 2'b00, 4'b1100, 5'd1, 5'd2, 5'd17);
        push_exp(1, EXC, 8'h00);
        push_exp(1, EXW, 8'h00);
        push_exp(1, EXRS, 8'd0);
        push_exp(1, MEMW, 8'h02);
        push_exp(1, MEMD, 8'd16);
        push_exp(2, WBW, 8'h02);
        push_exp(2, WBD, 8'd16);
        push_exp(2, MEMW, 8'h00);
        push_exp(2, MEMD, 8'd0);
        tick();
        flush = 1'b0;
        idle(4);

        // Asynchronous reset mid-operation, then normal load on first edge after.
        tid = 6;
        drive(1'b1, 2'b11, 2'b10, 4'b1011, 5'd1, 5'd2, 5'd3);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b1100, 5'd2, 5'd5, 5'd6);
        reset = 1'b1;
        for (int s = 0; s < NSEL; s++) push_exp(0, s, 8'h00);
        tick();
        reset = 1'b0;
        push_exp(0, HAZ, 8'h00);
        push_exp(1, EXC, 8'h0c);
        push_exp(1, EXRS, 8'd2);
        push_exp(1, MEMW, 8'h00);
        tick();
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
